// File: rtl/pipe2_issue_pkg.sv
// Shared definitions for the pipe2 issue stage: instruction field layout,
// bubble encoding and scoreboard depth.
package pipe2_issue_pkg;

  // Instruction word field positions
  localparam int FUNC_HI = 31;
  localparam int FUNC_LO = 28;
  localparam int RD_HI   = 27;
  localparam int RD_LO   = 24;
  localparam int RS1_HI  = 23;
  localparam int RS1_LO  = 20;
  localparam int RS2_HI  = 19;
  localparam int RS2_LO  = 16;
  localparam int ADDR_HI = 15;
  localparam int ADDR_LO = 8;

  // A bubble carries this opcode so pipe2 treats it as a no-op
  localparam logic [3:0] BUBBLE_FUNC = 4'b1111;

  // Register index that bubbles write into by default
  localparam int DEFAULT_BUBBLE_REG = 15;

  // pipe2 writes the register bank three edges after issue, so the
  // two following slots must not read a register the slot wrote
  localparam int SB_DEPTH = 2;

  // Decoded instruction as it is buffered and issued
  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] addr;
  } instr_t;

  localparam int INSTR_W = $bits(instr_t);

endpackage

// File: rtl/issue_fifo.sv
// Instruction buffer: FIFO with wrap-around pointers and an occupancy count.
// Push is ignored when full, pop is ignored when empty.
module issue_fifo
  import pipe2_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = INSTR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Next pointer and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  // Storage write for the accepted entry
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = wdata;
  end

  // Control state: pointers and occupancy cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless until the count covers them
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pipe2_issue.sv
// Issue stage in front of pipe2: buffers instructions, tracks the rd of the
// last two issue slots and inserts bubbles while the head would read a
// register that pipe2 has not yet written back.
module pipe2_issue
  import pipe2_issue_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BUBBLE_REG = DEFAULT_BUBBLE_REG
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] rs1,
  output logic [15:0] rs2,
  output logic [15:0] rd,
  output logic [3:0]  func,
  output logic [7:0]  addr,
  output logic        issue_valid,
  output logic        stall
);

  localparam logic [3:0] BUBBLE_RD = BUBBLE_REG[3:0];
  localparam instr_t BUBBLE_SLOT = '{func: BUBBLE_FUNC, rd: BUBBLE_RD,
                                     rs1: 4'd0, rs2: 4'd0, addr: 8'd0};

  instr_t              in_ins;
  instr_t              head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                hazard;
  logic                issue_now;
  logic                unused_low;

  instr_t              slot_q, slot_d;
  logic                issue_valid_q, issue_valid_d;
  logic                stall_q, stall_d;
  logic [3:0]          sb_rd_q [SB_DEPTH];
  logic [3:0]          sb_rd_d [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_vld_q, sb_vld_d;

  assign in_ins = '{func: in_instr[FUNC_HI:FUNC_LO],
                    rd:   in_instr[RD_HI:RD_LO],
                    rs1:  in_instr[RS1_HI:RS1_LO],
                    rs2:  in_instr[RS2_HI:RS2_LO],
                    addr: in_instr[ADDR_HI:ADDR_LO]};

  // Low byte of the instruction word carries nothing for this stage
  assign unused_low = ^in_instr[ADDR_LO-1:0];

  issue_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (in_ins),
    .pop   (issue_now),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;

  // Head is blocked when a source matches a live, non-sink rd of the last two slots
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_vld_q[i] && (sb_rd_q[i] != BUBBLE_RD) &&
          ((head.rs1 == sb_rd_q[i]) || (head.rs2 == sb_rd_q[i]))) begin
        hazard = 1'b1;
      end
    end
    issue_now = !fifo_empty && !hazard;
  end

  // Choose this edge's slot contents and shift the scoreboard
  always_comb begin
    slot_d        = BUBBLE_SLOT;
    issue_valid_d = 1'b0;
    stall_d       = !fifo_empty && hazard;
    if (issue_now) begin
      slot_d        = head;
      issue_valid_d = 1'b1;
    end
    sb_rd_d[0] = slot_d.rd;
    for (int i = 1; i < SB_DEPTH; i++) begin
      sb_rd_d[i] = sb_rd_q[i-1];
    end
    sb_vld_d = {sb_vld_q[SB_DEPTH-2:0], issue_valid_d};
  end

  // Issue-slot registers and scoreboard valid bits; reset to a clean bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q        <= BUBBLE_SLOT;
      issue_valid_q <= 1'b0;
      stall_q       <= 1'b0;
      sb_vld_q      <= '0;
    end else begin
      slot_q        <= slot_d;
      issue_valid_q <= issue_valid_d;
      stall_q       <= stall_d;
      sb_vld_q      <= sb_vld_d;
    end
  end

  // Scoreboard rd values only matter where the matching valid bit is set
  always_ff @(posedge clk) begin
    sb_rd_q <= sb_rd_d;
  end

  assign func        = slot_q.func;
  assign rd          = {12'd0, slot_q.rd};
  assign rs1         = {12'd0, slot_q.rs1};
  assign rs2         = {12'd0, slot_q.rs2};
  assign addr        = slot_q.addr;
  assign issue_valid = issue_valid_q;
  assign stall       = stall_q;

endmodule
